// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg
// Shared definitions for the AXIS data FIFO read-side adapter.
//   occ_e        : occupancy of the two-entry output buffer (EMPTY/ONE/FULL)
//   axis_word_t  : FIFO word layout {tlast, tkeep, tdata} at the default widths
//   field offsets: bit positions of each field inside a FIFO word
package axis_fifo_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int AXIS_FIFO_W = AXIS_DATA_W + AXIS_KEEP_W + 1;

  // Field offsets for the default widths
  localparam int TDATA_LSB = 0;
  localparam int TKEEP_LSB = AXIS_DATA_W;
  localparam int TLAST_BIT = AXIS_DATA_W + AXIS_KEEP_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic                   tlast;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_word_t;

  // Word width implied by a given data/keep width
  function automatic int fifo_word_w(input int dw, input int kw);
    return dw + kw + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_rd_if_skid.sv
// axis_skid_buf
// Two-register output buffer with occupancy FSM. 'main' always drives the
// outputs; 'skid' holds one spare word so the upstream pop never depends
// combinationally on downstream ready.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       a word is written this cycle (must only be high when o_can_push)
//   i_data       word to write
//   o_can_push   buffer has room (occupancy != FULL)
//   o_valid      main holds a word
//   o_data       contents of main
//   i_ready      downstream ready
//   o_xfer       a word leaves main this cycle
module axis_skid_buf
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH = AXIS_FIFO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_can_push,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic             o_xfer
);

  occ_e             r_occ;
  occ_e             w_occ_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_xfer;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  // Derived from registered state only, so no path from i_ready back to o_valid
  assign w_xfer = (r_occ != EMPTY) && i_ready;
  assign o_xfer = w_xfer;
  assign o_data = r_main;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= EMPTY;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_occ_next = r_occ;
    unique case (r_occ)
      EMPTY: if (i_push) w_occ_next = ONE;
      ONE: begin
        if (i_push && !w_xfer)      w_occ_next = FULL;
        else if (!i_push && w_xfer) w_occ_next = EMPTY;
      end
      FULL:    if (w_xfer) w_occ_next = ONE;
      default: w_occ_next = EMPTY;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    o_valid          = (r_occ != EMPTY);
    o_can_push       = (r_occ != FULL);
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_occ)
      EMPTY: w_load_main_in = i_push;
      ONE: begin
        // Word leaving and word arriving together: replace main, no bubble
        w_load_main_in = i_push && w_xfer;
        w_load_skid    = i_push && !w_xfer;
      end
      FULL:    w_load_main_skid = w_xfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= i_data;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= i_data;
    end
  end

endmodule

// File: rtl/axis_fifo_rd_if.sv
// axis_fifo_rd_if
// AXI-Stream master on the read side of the async AXIS data FIFO. Pops the
// show-ahead FIFO into a two-entry buffer and counts packets (tlast beats).
// Ports:
//   rd_clk, rd_rst_n   read clock, asynchronous active-low reset
//   fifo_rd_data       head-of-FIFO word {tlast, tkeep, tdata}
//   fifo_empty         FIFO empty flag
//   fifo_rd_en         pop request
//   m_axis_*           AXI4-Stream master
//   pkt_cnt            packets transferred since reset (wraps)
module axis_fifo_rd_if
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1,
  parameter int PKT_CNT_W  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [PKT_CNT_W-1:0]  pkt_cnt
);

  localparam int W_TKEEP_LSB = DATA_WIDTH;
  localparam int W_TLAST_BIT = DATA_WIDTH + KEEP_WIDTH;

  generate
    if (FIFO_WIDTH != fifo_word_w(DATA_WIDTH, KEEP_WIDTH)) begin : g_bad_fifo_width
      $error("axis_fifo_rd_if: FIFO_WIDTH must equal DATA_WIDTH+KEEP_WIDTH+1");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
      $error("axis_fifo_rd_if: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  logic                  w_can_push;
  logic                  w_xfer;
  logic [FIFO_WIDTH-1:0] w_out_word;
  logic [PKT_CNT_W-1:0]  r_pkt_cnt;

  assign fifo_rd_en = !fifo_empty && w_can_push;

  axis_skid_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_buf (
    .clk        (rd_clk),
    .rst_n      (rd_rst_n),
    .i_push     (fifo_rd_en),
    .i_data     (fifo_rd_data),
    .o_can_push (w_can_push),
    .o_valid    (m_axis_tvalid),
    .o_data     (w_out_word),
    .i_ready    (m_axis_tready),
    .o_xfer     (w_xfer)
  );

  assign m_axis_tdata = w_out_word[DATA_WIDTH-1:0];
  assign m_axis_tkeep = w_out_word[W_TLAST_BIT-1:W_TKEEP_LSB];
  assign m_axis_tlast = w_out_word[W_TLAST_BIT];

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_xfer && m_axis_tlast) begin
      r_pkt_cnt <= r_pkt_cnt + PKT_CNT_W'(1);
    end
  end

  assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_axis_fifo_rd_if.sv
module tb_axis_fifo_rd_if;
  import axis_fifo_pkg::*;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int FW = 37;
  localparam int CW = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b1;
  logic [FW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [CW-1:0] pkt_cnt;

  always #5 rd_clk = ~rd_clk;

  axis_fifo_rd_if #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .FIFO_WIDTH (FW),
    .PKT_CNT_W  (CW)
  ) dut (
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: the FIFO contents, the words held by the adapter,
  // and the full expected output stream in push order.
  axis_word_t    fifo_q[$];
  axis_word_t    buf_q[$];
  axis_word_t    sb_q[$];
  logic [CW-1:0] exp_cnt;
  int            pops, xfers, run_len, max_run;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic axis_word_t mk(input logic last, input logic [KW-1:0] keep,
                                    input logic [DW-1:0] data);
    axis_word_t w;
    w.tlast = last;
    w.tkeep = keep;
    w.tdata = data;
    return w;
  endfunction

  task automatic drive_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input axis_word_t w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
    drive_fifo();
  endtask

  task automatic model_clear();
    fifo_q.delete();
    buf_q.delete();
    sb_q.delete();
    exp_cnt = '0;
    drive_fifo();
  endtask

  // One clock cycle, entered and left at the falling edge. Compares every
  // DUT output against the model, then advances the model across the edge.
  task automatic cycle();
    logic       exp_valid, exp_rd_en, do_xfer;
    axis_word_t w, dut_w;
    #1;
    exp_valid = (buf_q.size() != 0);
    exp_rd_en = (fifo_q.size() != 0) && (buf_q.size() < 2);
    dut_w     = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    chk("rd_en", 64'(fifo_rd_en), 64'(exp_rd_en));
    chk("tvalid", 64'(m_axis_tvalid), 64'(exp_valid));
    if (exp_valid) chk("word", 64'(dut_w), 64'(buf_q[0]));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
    do_xfer = exp_valid && m_axis_tready;
    if (do_xfer) begin
      w = sb_q.pop_front();
      chk("order", 64'(dut_w), 64'(w));
      $display("xfer data=%08h keep=%h last=%b pkt_cnt=%0d", m_axis_tdata, m_axis_tkeep,
               m_axis_tlast, pkt_cnt);
    end
    @(posedge rd_clk);
    if (do_xfer) begin
      w = buf_q.pop_front();
      if (w.tlast) exp_cnt = exp_cnt + 1'b1;
      xfers++;
    end
    if (exp_rd_en) begin
      buf_q.push_back(fifo_q.pop_front());
      pops++;
    end
    if (exp_valid) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    @(negedge rd_clk);
    drive_fifo();
  endtask

  task automatic stats_clear();
    pops = 0; xfers = 0; run_len = 0; max_run = 0;
  endtask

  initial begin
    int wrap_exp[5];
    wrap_exp = '{1, 2, 3, 0, 1};
    m_axis_tready = 1'b0;
    model_clear();
    stats_clear();
    #1 rd_rst_n = 1'b0;
    @(negedge rd_clk); #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;

    // Single beat
    m_axis_tready = 1'b1;
    push(mk(1'b1, 4'hF, 32'hDEADBEEF));
    #1 chk("t1_rd_en", 64'(fifo_rd_en), 64'd1);
    cycle();
    chk("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t1_tdata", 64'(m_axis_tdata), 64'hDEADBEEF);
    chk("t1_tkeep", 64'(m_axis_tkeep), 64'hF);
    chk("t1_tlast", 64'(m_axis_tlast), 64'd1);
    cycle();
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("t1_tvalid_low", 64'(m_axis_tvalid), 64'd0);

    // Streaming: 8 back-to-back words
    stats_clear();
    for (int i = 0; i < 8; i++) push(mk(i == 7, 4'hF, 32'(i)));
    repeat (11) cycle();
    chk("stream_pops", 64'(pops), 64'd8);
    chk("stream_xfers", 64'(xfers), 64'd8);
    chk("stream_run", 64'(max_run), 64'd8);

    // Backpressure: 6 queued, ready low for 5 cycles
    stats_clear();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) push(mk(i == 5, 4'h3, 32'h100 + 32'(i)));
    repeat (5) cycle();
    chk("bp_pops", 64'(pops), 64'd2);
    #1 chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("bp_tdata", 64'(m_axis_tdata), 64'h100);
    m_axis_tready = 1'b1;
    repeat (10) cycle();
    chk("bp_pops_total", 64'(pops), 64'd6);
    chk("bp_xfers", 64'(xfers), 64'd6);

    // Gap: drain then refill
    for (int i = 0; i < 3; i++) push(mk(i == 2, 4'hF, 32'h200 + 32'(i)));
    repeat (6) cycle();
    chk("gap_tvalid_low", 64'(m_axis_tvalid), 64'd0);
    push(mk(1'b1, 4'h1, 32'h300));
    cycle();
    chk("gap_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("gap_tdata", 64'(m_axis_tdata), 64'h300);
    cycle();

    // Reset with the buffer full
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(i == 3, 4'hF, 32'h500 + 32'(i)));
    repeat (3) cycle();
    chk("rm_tvalid_pre", 64'(m_axis_tvalid), 64'd1);
    #2 rd_rst_n = 1'b0;
    model_clear();
    #1;
    chk("rm_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rm_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rm_rd_en", 64'(fifo_rd_en), 64'd0);
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;

    // Counter wrap with a 2-bit counter
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(mk(1'b1, 4'hF, 32'h400 + 32'(i)));
      repeat (3) cycle();
      chk("wrap_cnt", 64'(pkt_cnt), 64'(wrap_exp[i][CW-1:0]));
    end

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) < 60)
        push(mk($urandom_range(0, 3) == 0, 4'($urandom), $urandom));
      m_axis_tready = ($urandom_range(0, 99) < 70);
      cycle();
    end
    m_axis_tready = 1'b1;
    while (fifo_q.size() != 0 || buf_q.size() != 0) cycle();
    cycle();
    chk("drain_tvalid", 64'(m_axis_tvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
